// File: rtl/divu_seq_if.sv
// Handshake and operand bus for the sequential unsigned divider.
// The requester drives the function code, strobe and operands; the divider returns status and results.
interface divu_seq_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       signal;
    logic             start;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output signal, start, dataA, dataB,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  signal, start, dataA, dataB,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/divu_seq.sv
// Restoring shift-subtract unsigned divider for the DIVU function code.
// Produces one quotient bit per clock and then pulses done for one cycle.
module divu_seq #(
    parameter int         WIDTH = 32,
    parameter logic [5:0] DIVU  = 6'd27
) (
    input logic          clk,
    input logic          reset,
    divu_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_lastIter;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_remNext;
    logic [WIDTH-1:0] w_quoNext;
    logic             w_busy;
    logic             w_done;

    assign w_accept   = (r_state == IDLE) && bus.start && (bus.signal == DIVU);
    assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

    // A clear sign bit on the trial difference means the divisor fits, so keep it and emit a 1.
    assign w_shifted = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, r_dvs};
    assign w_remNext = w_diff[WIDTH] ? w_shifted : w_diff;
    assign w_quoNext = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_lastIter) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Results are latched on the final iteration so they stay stable for the whole next division.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_quo <= bus.dataA;
            r_dvs <= bus.dataB;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
            r_cnt <= r_cnt + CW'(1);
            if (w_lastIter) begin
                r_quotient  <= w_quoNext;
                r_remainder <= w_remNext[WIDTH-1:0];
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
endmodule

// File: tb/tb_divu_seq.sv
// Directed self-checking bench for divu_seq: latency, results, ignored starts and async abort.
// Edge numbering: start is applied just after edge 0 and sampled at edge 1.
module tb_divu_seq;
    localparam int         WIDTH = 32;
    localparam logic [5:0] DIVU  = 6'd27;
    localparam logic [5:0] ADD   = 6'd32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    divu_seq_if #(.WIDTH(WIDTH)) bus ();

    divu_seq #(.WIDTH(WIDTH), .DIVU(DIVU)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Runs one division from edge 0 to edge 36 and checks latency, pulse width and results.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expQ, input logic [31:0] expR,
                                 input string tag, input bit disturb, input bit holdStart);
        int          doneEdge;
        int          busyCount;
        int          doneCount;
        bit          changed;
        logic [31:0] qBefore;
        logic [31:0] rBefore;
        logic [31:0] qAtDone;
        logic [31:0] rAtDone;
        @(posedge clk);
        #1;
        qBefore    = bus.quotient;
        rBefore    = bus.remainder;
        qAtDone    = 32'hDEAD_BEEF;
        rAtDone    = 32'hDEAD_BEEF;
        doneEdge   = -1;
        busyCount  = 0;
        doneCount  = 0;
        changed    = 1'b0;
        bus.signal = DIVU;
        bus.dataA  = a;
        bus.dataB  = b;
        bus.start  = 1'b1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc <= 33 && bus.busy === 1'b1) busyCount++;
            if (bus.done === 1'b1) begin
                doneCount++;
                if (doneEdge < 0) begin
                    doneEdge = cyc;
                    qAtDone  = bus.quotient;
                    rAtDone  = bus.remainder;
                end
            end
            if (cyc < 33 && (bus.quotient !== qBefore || bus.remainder !== rBefore)) changed = 1'b1;
            if (cyc == 1 && !holdStart) bus.start = 1'b0;
            if (disturb && cyc == 5) begin
                bus.start = 1'b1;
                bus.dataA = 32'd50;
                bus.dataB = 32'd5;
            end
            if (disturb && cyc == 6) begin
                bus.start = holdStart;
                bus.dataA = 32'd77;
            end
            if (holdStart && cyc == 34) begin
                checkOutput({tag, "_idleAfterDone"}, bus.busy, 1'b0);
                bus.dataA = 32'd1000;
                bus.dataB = 32'd3;
            end
            if (holdStart && cyc == 35) begin
                checkOutput({tag, "_firstIdleAccept"}, bus.busy, 1'b1);
                bus.start = 1'b0;
            end
        end
        checkOutput({tag, "_busyCycles"}, busyCount, 32);
        checkOutput({tag, "_doneEdge"}, doneEdge, 33);
        checkOutput({tag, "_donePulses"}, doneCount, 1);
        checkOutput({tag, "_quotient"}, qAtDone, expQ);
        checkOutput({tag, "_remainder"}, rAtDone, expR);
        checkOutput({tag, "_stableDuringRun"}, changed, 1'b0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seenBusy;
        bit seenDone;
        bit held;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.signal = 6'd0;
        bus.start  = 1'b0;
        bus.dataA  = '0;
        bus.dataB  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstBusy", bus.busy, 1'b0);
        checkOutput("rstDone", bus.done, 1'b0);
        checkOutput("rstQuotient", bus.quotient, 32'd0);
        checkOutput("rstRemainder", bus.remainder, 32'd0);

        // A start carrying a different function code must not launch anything.
        seenBusy   = 1'b0;
        seenDone   = 1'b0;
        bus.signal = ADD;
        bus.dataA  = 32'd100;
        bus.dataB  = 32'd7;
        bus.start  = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1) seenBusy = 1'b1;
            if (bus.done === 1'b1) seenDone = 1'b1;
        end
        bus.start = 1'b0;
        checkOutput("addIgnoredBusy", seenBusy, 1'b0);
        checkOutput("addIgnoredDone", seenDone, 1'b0);

        applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, "div100by7", 1'b0, 1'b0);

        held = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.busy !== 1'b0) held = 1'b0;
        end
        checkOutput("holdIdle", held, 1'b1);

        applyStimulus(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "divMaxBy1", 1'b0, 1'b0);
        applyStimulus(32'd5, 32'd9, 32'd0, 32'd5, "div5by9", 1'b0, 1'b0);
        applyStimulus(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "divByZero", 1'b0, 1'b0);
        applyStimulus(32'd1000, 32'd3, 32'd333, 32'd1, "div1000by3", 1'b1, 1'b1);

        // A second 1000/3 was accepted at edge 35 and has one iteration behind it; abort at iteration 10.
        repeat (9) @(posedge clk);
        #1;
        checkOutput("abortPreBusy", bus.busy, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("abortBusy", bus.busy, 1'b0);
        checkOutput("abortDone", bus.done, 1'b0);
        checkOutput("abortQuotient", bus.quotient, 32'd0);
        checkOutput("abortRemainder", bus.remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(32'd81, 32'd9, 32'd9, 32'd0, "div81by9", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
